// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package add_ctrl_pkg;

    localparam int unsigned SLICE_W         = 4;
    localparam int unsigned NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response bundle between a requester (master) and the serial adder (slave).
interface nibble_serial_add_ctrl_if #(
    parameter int unsigned NIBBLES = add_ctrl_pkg::NIBBLES_DEFAULT
) ();

    localparam int unsigned W = add_ctrl_pkg::SLICE_W * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/nibble_serial_add_ctrl_adder4_slice.sv
// Combinational 4-bit ripple-carry slice; c_msb is the carry into the top bit.
module adder4_slice
    import add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[SLICE_W];
    assign c_msb = c[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract: one 4-bit slice reused LSB-first over NIBBLES cycles,
// with valid/ready handshakes on both sides.
module nibble_serial_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef logic [NIBBLES-1:0][SLICE_W-1:0] word_t;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    word_t           a_q, a_d;
    word_t           b_q, b_d;
    word_t           sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    word_t              in_a_n, in_b_n;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_c_msb;

    assign in_a_n = bus.in_a;
    assign in_b_n = bus.in_b;

    adder4_slice u_slice (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    // Subtract as A + ~B + 1; in_cin is irrelevant then.
                    a_d     = in_a_n;
                    b_d     = bus.in_sub ? ~in_b_n : in_b_n;
                    carry_d = bus.in_sub ? 1'b1 : bus.in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q] = slice_sum;
                carry_d      = slice_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_c_msb ^ slice_cout;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed-vector bench for nibble_serial_add_ctrl with NIBBLES=4.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Returns the number of cycles from the accepting edge to out_valid.
    task automatic accept_and_wait(input vec_t v, input bit scramble, output int lat);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_cin   = v.cin;
        bus.in_sub   = v.sub;
        tick();
        lat = 0;
        if (!scramble) bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            if (scramble) begin
                bus.in_a   = W'($urandom);
                bus.in_b   = W'($urandom);
                bus.in_cin = 1'($urandom);
                bus.in_sub = 1'($urandom);
            end else begin
                bus.in_a = ~v.a;
                bus.in_b = ~v.b;
            end
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
    endtask

    vec_t vecs[8];
    int   lat;
    int   t_acc[2];
    int   found;
    int   vcount;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[6] = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_cout_ovf", {30'd0, bus.out_cout, bus.out_ovf}, 32'd0);

        // Reset wins over a simultaneous accept.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1111;
        tick();
        check("rst_prio_busy", 32'(bus.busy), 32'd0);
        check("rst_prio_in_ready", 32'(bus.in_ready), 32'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            accept_and_wait(vecs[i], 1'b0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(N));
            check($sformatf("v%0d_sum", i), 32'(bus.out_sum), 32'(vecs[i].sum));
            check($sformatf("v%0d_cout", i), 32'(bus.out_cout), 32'(vecs[i].cout));
            check($sformatf("v%0d_ovf", i), 32'(bus.out_ovf), 32'(vecs[i].ovf));
            tick();
            check($sformatf("v%0d_ready_after", i), {30'd0, bus.in_ready, bus.out_valid},
                  32'b10);
        end

        // Operands change under a held in_valid; result must use the captured pair.
        // Then stall the result for three cycles.
        bus.out_ready = 1'b0;
        accept_and_wait(vecs[0], 1'b1, lat);
        check("hold_latency", 32'(lat), 32'(N));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d_valid_ready", k), {30'd0, bus.out_valid, bus.in_ready},
                  32'b10);
            check($sformatf("stall%0d_sum", k), 32'(bus.out_sum), 32'h5555);
            check($sformatf("stall%0d_cout_ovf", k), {30'd0, bus.out_cout, bus.out_ovf}, 32'd0);
            check($sformatf("stall%0d_busy", k), 32'(bus.busy), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back: in_valid and out_ready held high.
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0001;
        bus.in_b     = 16'h0002;
        bus.in_sub   = 1'b0;
        found        = 0;
        for (int k = 0; k < 40 && found < 2; k++) begin
            if (bus.in_ready) begin
                t_acc[found] = cyc;
                found++;
            end
            if (found < 2) tick();
        end
        check("b2b_found", 32'(found), 32'd2);
        check("b2b_spacing", 32'(t_acc[1] - t_acc[0]), 32'(N + 2));
        tick();
        bus.in_valid = 1'b0;
        wait_ready();

        // Reset while RUN is processing nibble index 2.
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h4321;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.out_valid) vcount++;
        end
        check("mid_rst_no_valid", 32'(vcount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
